rstack_ctrl: RTL and testbench
==============================

Name: rstack_ctrl

Overview:
Return-stack controller directly upstream of the return-stack RAM (async read, sync write, SIZE entries) in the brus16 CPU. It takes push (call) and pop (ret) requests from the decode stage and keeps the top entry cached in a register, so the CPU reads the return address with zero latency. It drives the RAM address, write-enable and data, and reports depth, empty/full and error status.

Parameters:
WIDTH, 13, RAM address width; RAM SIZE = 2**WIDTH
DATA_WIDTH, 16, entry width
(capacity = SIZE + 1 entries: SIZE in RAM plus the cached top)

Ports:
clk  in  1  clock; all state changes on the rising edge
rst_n  in  1  synchronous active-low reset
push  in  1  push push_data this cycle
pop  in  1  pop the top entry this cycle
push_data  in  DATA_WIDTH  value to push (return address)
flush  in  1  synchronous clear of the stack; takes priority over push/pop
err_clr  in  1  clear the sticky error flags
tos  out  DATA_WIDTH  registered top of stack
depth  out  WIDTH+1  entries held, 0..SIZE+1
empty  out  1  depth == 0
full  out  1  depth == SIZE+1
overflow  out  1  sticky: push attempted while full
underflow  out  1  sticky: pop attempted while empty
mem_dout_addr  out  WIDTH  RAM read address = sp-1 (mod SIZE), combinational
mem_dout  in  DATA_WIDTH  RAM async read data
mem_we  out  1  RAM write enable
mem_din_addr  out  WIDTH  RAM write address = sp
mem_din  out  DATA_WIDTH  RAM write data = tos

Behaviour:
- State: tos reg, depth reg (WIDTH+1 bits), sp reg (WIDTH bits; next free RAM slot; sp == depth-1 when depth>0, else 0), overflow/underflow regs.
- Reset (rst_n=0 at edge): tos=0, depth=0, sp=0, overflow=0, underflow=0. mem_we=0 whenever rst_n=0. RAM contents are not cleared.
- empty and full are combinational from depth. mem_din_addr=sp and mem_din=tos always.
- mem_we = rst_n & ~flush & push & ~pop & ~full & (depth>0).
- flush: depth=0, sp=0, tos=0. Flags are unchanged. push/pop are ignored that cycle.
- Push only, depth==0: tos<=push_data; depth=1; sp stays 0; no RAM write.
- Push only, 0<depth<=SIZE: RAM[sp]<=tos; tos<=push_data; sp+=1 (wraps to 0 only when depth reaches SIZE+1); depth+=1.
- Push only, full: no state change. overflow<=1 (guarded build only).
- Pop only, depth>=2: tos<=mem_dout (RAM[sp-1]); sp-=1; depth-=1.
- Pop only, depth==1: tos<=0; depth=0; sp stays 0.
- Pop only, empty: no state change. underflow<=1 (guarded build only).
- Push and pop in the same cycle, depth>=1: replace the top. tos<=push_data; depth and sp unchanged; no RAM write. This is legal when full.
- Push and pop in the same cycle, depth==0: behaves as a push (tos<=push_data, depth=1). underflow<=1 (guarded build only).
- err_clr clears both flags. A new error in the same cycle wins (the flag is set).
- Latency: tos, depth and flags are valid the cycle after the request edge. Back-to-back operations every cycle are supported.

Optional Feature:
RSTACK_GUARD_EN
- Defined: overflow and underflow are sticky as specified above; err_clr is honoured.
- Undefined: overflow=underflow=0 constantly and err_clr is ignored. Illegal operations are still silently ignored, so stack state is identical between the two builds.

Test Plan:
(Bench uses WIDTH=2, so SIZE=4 and capacity=5; the bench models the RAM.)
- Reset, then push 0x0100 -> tos=0x0100, depth=1, mem_we=0 that cycle, empty=0.
- Push 0x0100,0x0200,0x0300 back-to-back -> RAM[0]=0x0100, RAM[1]=0x0200, tos=0x0300, depth=3, sp=2. Then pop twice -> tos=0x0200 then 0x0100, depth=1.
- Push 5 values 0x11..0x15 -> full=1, depth=5. 6th push 0x16 -> state unchanged, overflow=1 (guarded) or 0 (unguarded). Pop 5 times -> tos sequence 0x14,0x13,0x12,0x11,0, empty=1.
- Depth 2, tos=0x0AAA: push+pop with push_data=0x0BBB -> tos=0x0BBB, depth=2, mem_we=0. Same at full -> depth stays 5, no overflow.
- Empty, pop -> underflow=1 (guarded), depth=0. err_clr together with another pop -> underflow stays 1. err_clr alone -> underflow=0.
- Depth 3, flush asserted with push 0x7777 -> depth=0, tos=0, mem_we=0. rst_n=0 mid-stream with push=1 -> all outputs reset, mem_we=0.

Source files
------------

// File: rtl/rstack_ctrl_if.sv
// Decode-stage and return-stack RAM signals of rstack_ctrl, bundled as one interface.
// master: CPU decode stage plus RAM side; slave: the controller.
interface rstack_ctrl_if #(
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  flush;
  logic                  err_clr;
  logic [DATA_WIDTH-1:0] tos;
  logic [WIDTH:0]        depth;
  logic                  empty;
  logic                  full;
  logic                  overflow;
  logic                  underflow;
  logic [WIDTH-1:0]      mem_dout_addr;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  mem_we;
  logic [WIDTH-1:0]      mem_din_addr;
  logic [DATA_WIDTH-1:0] mem_din;

  modport master (
    output push, pop, push_data, flush, err_clr, mem_dout,
    input  tos, depth, empty, full, overflow, underflow,
           mem_dout_addr, mem_we, mem_din_addr, mem_din
  );

  modport slave (
    input  push, pop, push_data, flush, err_clr, mem_dout,
    output tos, depth, empty, full, overflow, underflow,
           mem_dout_addr, mem_we, mem_din_addr, mem_din
  );
endinterface

// File: rtl/rstack_ctrl.sv
// Return-stack controller with cached top entry in front of an async-read RAM.
// Optional RSTACK_GUARD_EN enables sticky overflow/underflow flags and err_clr.
module rstack_ctrl #(
  parameter int unsigned WIDTH      = 13,
  parameter int unsigned DATA_WIDTH = 16
) (
  input logic         clk,
  input logic         rst_n,
  rstack_ctrl_if.slave bus
);
  localparam logic [WIDTH:0] CAP = (WIDTH+1)'(2**WIDTH + 1);

  logic [DATA_WIDTH-1:0] tos_q;
  logic [WIDTH:0]        depth_q;
  logic [WIDTH-1:0]      sp_q;
  logic                  full_w;
  logic                  empty_w;

  assign empty_w           = (depth_q == '0);
  assign full_w            = (depth_q == CAP);
  assign bus.tos           = tos_q;
  assign bus.depth         = depth_q;
  assign bus.empty         = empty_w;
  assign bus.full          = full_w;
  assign bus.mem_din_addr  = sp_q;
  assign bus.mem_din       = tos_q;
  assign bus.mem_dout_addr = sp_q - 1'b1;
  assign bus.mem_we        = rst_n & ~bus.flush & bus.push & ~bus.pop & ~full_w & ~empty_w;

  // sp only moves while the RAM holds entries; going full wraps it to 0 naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tos_q   <= '0;
      depth_q <= '0;
      sp_q    <= '0;
    end else if (bus.flush) begin
      tos_q   <= '0;
      depth_q <= '0;
      sp_q    <= '0;
    end else if (bus.push && bus.pop) begin
      tos_q <= bus.push_data;
      if (empty_w) depth_q <= (WIDTH+1)'(1);
    end else if (bus.push) begin
      if (!full_w) begin
        tos_q   <= bus.push_data;
        depth_q <= depth_q + 1'b1;
        if (!empty_w) sp_q <= sp_q + 1'b1;
      end
    end else if (bus.pop) begin
      if (depth_q > (WIDTH+1)'(1)) begin
        tos_q   <= bus.mem_dout;
        sp_q    <= sp_q - 1'b1;
        depth_q <= depth_q - 1'b1;
      end else if (!empty_w) begin
        tos_q   <= '0;
        depth_q <= '0;
      end
    end
  end

`ifdef RSTACK_GUARD_EN
  logic ov_q;
  logic un_q;
  logic set_ov;
  logic set_un;

  assign set_ov = ~bus.flush & bus.push & ~bus.pop & full_w;
  assign set_un = ~bus.flush & bus.pop & empty_w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ov_q <= 1'b0;
      un_q <= 1'b0;
    end else begin
      if (set_ov)           ov_q <= 1'b1;
      else if (bus.err_clr) ov_q <= 1'b0;
      if (set_un)           un_q <= 1'b1;
      else if (bus.err_clr) un_q <= 1'b0;
    end
  end

  assign bus.overflow  = ov_q;
  assign bus.underflow = un_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.overflow   = 1'b0;
  assign bus.underflow  = 1'b0;
`endif
endmodule

// File: tb/tb_rstack_ctrl.sv
// Bench for rstack_ctrl (WIDTH=2): queue-based stack model checked every cycle,
// a modelled RAM behind the controller, and directed scenarios with literal values.
module tb_rstack_ctrl;
  localparam int unsigned W    = 2;
  localparam int unsigned DW   = 16;
  localparam int unsigned SIZE = 4;
  localparam int unsigned CAPN = SIZE + 1;
`ifdef RSTACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rstack_ctrl_if #(.WIDTH(W), .DATA_WIDTH(DW)) bus ();
  rstack_ctrl #(.WIDTH(W), .DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // RAM: async read, sync write
  logic [DW-1:0] ram [SIZE];
  assign bus.mem_dout = ram[bus.mem_dout_addr];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_din_addr] <= bus.mem_din;

  int passes = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: the stack is a queue, top at the back
  logic [DW-1:0] q[$];
  bit m_ov = 1'b0;
  bit m_un = 1'b0;

  always @(posedge clk) begin
    bit nov, nun;
    nov = 1'b0;
    nun = 1'b0;
    if (!rst_n) begin
      q.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (bus.flush) q.delete();
      else if (bus.push && bus.pop) begin
        if (q.size() == 0) begin q.push_back(bus.push_data); nun = 1'b1; end
        else q[q.size()-1] = bus.push_data;
      end else if (bus.push) begin
        if (q.size() == CAPN) nov = 1'b1;
        else q.push_back(bus.push_data);
      end else if (bus.pop) begin
        if (q.size() == 0) nun = 1'b1;
        else void'(q.pop_back());
      end
      if (GUARD) begin
        m_ov = nov ? 1'b1 : (bus.err_clr ? 1'b0 : m_ov);
        m_un = nun ? 1'b1 : (bus.err_clr ? 1'b0 : m_un);
      end
    end
  end

  // Compare process: registered outputs and the combinational RAM controls
  always @(negedge clk) begin
    int unsigned n, sp;
    logic [DW-1:0] etos;
    logic ewe;
    n    = q.size();
    sp   = (n == 0) ? 0 : (n - 1) % SIZE;
    etos = (n == 0) ? '0 : q[n-1];
    ewe  = rst_n & ~bus.flush & bus.push & ~bus.pop & (n < CAPN) & (n > 0);
    chk("tos",        32'(bus.tos), 32'(etos));
    chk("depth",      32'(bus.depth), 32'(n));
    chk("empty",      32'(bus.empty), 32'(n == 0));
    chk("full",       32'(bus.full), 32'(n == CAPN));
    chk("overflow",   32'(bus.overflow), 32'(m_ov));
    chk("underflow",  32'(bus.underflow), 32'(m_un));
    chk("din_addr",   32'(bus.mem_din_addr), 32'(sp));
    chk("din",        32'(bus.mem_din), 32'(etos));
    chk("dout_addr",  32'(bus.mem_dout_addr), 32'((sp + SIZE - 1) % SIZE));
    chk("mem_we",     32'(bus.mem_we), 32'(ewe));
  end

  logic we_seen;

  task automatic op(input logic pu, input logic po, input logic [DW-1:0] d,
                    input logic fl = 1'b0, input logic ec = 1'b0);
    bus.push = pu; bus.pop = po; bus.push_data = d; bus.flush = fl; bus.err_clr = ec;
    #1 we_seen = bus.mem_we;
    @(posedge clk);
    #1;
    bus.push = 1'b0; bus.pop = 1'b0; bus.flush = 1'b0; bus.err_clr = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] pop_seq [5];
    pop_seq = '{16'h14, 16'h13, 16'h12, 16'h11, 16'h0};
    rst_n = 1'b0;
    bus.push = 1'b0; bus.pop = 1'b0; bus.push_data = '0; bus.flush = 1'b0; bus.err_clr = 1'b0;
    op(0, 0, 0); op(0, 0, 0);
    rst_n = 1'b1;
    chk("rst_depth", 32'(bus.depth), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_tos",   32'(bus.tos), 0);

    op(1, 0, 16'h0100);
    chk("p1_we", 32'(we_seen), 0);
    chk("p1_tos", 32'(bus.tos), 32'h0100);
    chk("p1_empty", 32'(bus.empty), 0);
    op(1, 0, 16'h0200); op(1, 0, 16'h0300);
    chk("p3_tos", 32'(bus.tos), 32'h0300);
    chk("p3_depth", 32'(bus.depth), 3);
    chk("p3_sp", 32'(bus.mem_din_addr), 2);
    chk("ram0", 32'(ram[0]), 32'h0100);
    chk("ram1", 32'(ram[1]), 32'h0200);
    op(0, 1, 0);
    chk("pop1_tos", 32'(bus.tos), 32'h0200);
    op(0, 1, 0);
    chk("pop2_tos", 32'(bus.tos), 32'h0100);
    chk("pop2_depth", 32'(bus.depth), 1);
    op(0, 1, 0);

    for (int i = 0; i < 5; i++) op(1, 0, DW'(16'h11 + i));
    chk("fill_full", 32'(bus.full), 1);
    chk("fill_depth", 32'(bus.depth), 5);
    op(1, 0, 16'h16);
    chk("ovf_depth", 32'(bus.depth), 5);
    chk("ovf_tos", 32'(bus.tos), 32'h15);
    chk("ovf_flag", 32'(bus.overflow), 32'(GUARD));
    for (int i = 0; i < 5; i++) begin
      op(0, 1, 0);
      chk("drain_tos", 32'(bus.tos), 32'(pop_seq[i]));
    end
    chk("drain_empty", 32'(bus.empty), 1);
    op(0, 0, 0, 0, 1);
    chk("ovf_clr", 32'(bus.overflow), 0);

    op(1, 0, 16'h0999); op(1, 0, 16'h0AAA);
    op(1, 1, 16'h0BBB);
    chk("rep_we", 32'(we_seen), 0);
    chk("rep_tos", 32'(bus.tos), 32'h0BBB);
    chk("rep_depth", 32'(bus.depth), 2);
    op(0, 1, 0);
    chk("rep_below", 32'(bus.tos), 32'h0999);
    op(1, 0, 16'h0C01); op(1, 0, 16'h0C02); op(1, 0, 16'h0C03); op(1, 0, 16'h0C04);
    op(1, 1, 16'h0DDD);
    chk("repf_depth", 32'(bus.depth), 5);
    chk("repf_tos", 32'(bus.tos), 32'h0DDD);
    chk("repf_ovf", 32'(bus.overflow), 0);
    op(0, 1, 0);
    chk("repf_pop", 32'(bus.tos), 32'h0C03);

    op(0, 0, 0, 1);
    op(0, 1, 0);
    chk("unf_flag", 32'(bus.underflow), 32'(GUARD));
    chk("unf_depth", 32'(bus.depth), 0);
    op(0, 1, 0, 0, 1);
    chk("unf_win", 32'(bus.underflow), 32'(GUARD));
    op(0, 0, 0, 0, 1);
    chk("unf_clr", 32'(bus.underflow), 0);
    op(1, 1, 16'h0123);
    chk("pp0_depth", 32'(bus.depth), 1);
    chk("pp0_tos", 32'(bus.tos), 32'h0123);
    chk("pp0_unf", 32'(bus.underflow), 32'(GUARD));
    op(0, 0, 0, 0, 1);

    op(1, 0, 16'h0A01); op(1, 0, 16'h0A02);
    op(1, 0, 16'h7777, 1);
    chk("fl_we", 32'(we_seen), 0);
    chk("fl_depth", 32'(bus.depth), 0);
    chk("fl_tos", 32'(bus.tos), 0);
    op(1, 0, 16'h0B01); op(1, 0, 16'h0B02);
    rst_n = 1'b0;
    op(1, 0, 16'h0B03);
    chk("rs_we", 32'(we_seen), 0);
    chk("rs_depth", 32'(bus.depth), 0);
    chk("rs_tos", 32'(bus.tos), 0);
    rst_n = 1'b1;
    op(0, 0, 0); op(0, 0, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
